issue_hazard_ctrl: RTL and testbench
====================================

Name: issue_hazard_ctrl

Overview:
Scoreboard-based issue controller for the in-order single-issue RV32 pipeline. It sits between OF and EX and decides each cycle whether the OF instruction may issue. It tracks per-register result-ready countdowns (loads, multi-cycle divide), arbitrates the single divider, and serialises CSR/fence-class instructions. It generates the IF and IF/OF stalls and the EX bubble; the forwarding path itself is handled elsewhere.

Parameters:
LATW, 4, width of each readiness countdown counter
LOAD_LAT, 1, cycles after issue before a load result is forwardable to OF (must be at least 1)
DIV_LAT, 8, cycles the divider is occupied and its result is unavailable (must be below 2^LATW)

Ports:
clk  input  1  clock
reset  input  1  reset; synchronous, active-high
of_valid  input  1  OF holds a valid instruction
of_rs1  input  5  source register 1
of_rs1_used  input  1  instruction reads rs1
of_rs2  input  5  source register 2
of_rs2_used  input  1  instruction reads rs2
of_rd  input  5  destination register
of_wb_en  input  1  instruction writes rd
of_class  input  2  0=ALU, 1=LOAD, 2=DIV, 3=SERIAL (CSR/fence)
flush  input  1  branch/jump redirect; squashes the OF instruction this cycle
issue_fire  output  1  OF instruction moves into EX this cycle
ex_bubble  output  1  EX receives a NOP this cycle
stall_if  output  1  hold PC/IF
stall_ifof  output  1  hold IF/OF register
sb_busy_mask  output  32  bit r set when cnt[r]!=0; bit 0 is always 0
stall_cycles  output  32  saturating count of cycles with stall_if high

Behaviour:
- State:
  - cnt[1..31] (LATW bits each).
  - div_cnt (LATW bits).
  - stall_cycles.
  - x0 is never tracked.
- Latency per class, lat(class):
  - ALU = 0.
  - LOAD = LOAD_LAT.
  - DIV = DIV_LAT.
  - SERIAL = 0.
- Hazard terms (combinational from current state):
  - raw: (of_rs1_used & of_rs1!=0 & cnt[of_rs1]!=0), OR the same test on rs2.
  - waw: of_wb_en & of_rd!=0 & cnt[of_rd] > lat(of_class).
  - structural: of_class==DIV & div_cnt!=0.
  - serial: of_class==SERIAL & (any cnt!=0 | div_cnt!=0).
  - hazard = OR of the four terms above.
- Outputs (all combinational, no added latency):
  - issue_fire = of_valid & ~flush & ~hazard.
  - stall_if = stall_ifof = of_valid & ~flush & hazard.
  - ex_bubble = ~issue_fire.
- Per-cycle register update:
  - Every nonzero cnt[r] and div_cnt decrements by 1.
  - On issue_fire & of_wb_en & of_rd!=0 & lat>0: cnt[of_rd] <= lat. This overrides the decrement of the same entry.
  - On issue_fire & of_class==DIV: div_cnt <= DIV_LAT.
  - stall_cycles increments when stall_if is high; it holds at 32'hFFFF_FFFF.
- Result availability: a counter reaching 0 means the result is on the forwarding path. A dependent instruction issues in the cycle cnt reads 0, never earlier.
- Flush:
  - No issue and no stall in that cycle; ex_bubble=1.
  - Counters keep decrementing, since older in-flight instructions still complete.
- of_valid=0: stall outputs 0, ex_bubble=1, no scoreboard write.
- Reset:
  - Clears all cnt, div_cnt and stall_cycles on the next edge, including mid-divide or mid-stall.
  - After reset: sb_busy_mask=0, stall_if=stall_ifof=0, issue_fire=of_valid&~flush.
- Simultaneous cases:
  - Reading a register whose cnt is 1 this cycle: stall. The instruction issues next cycle.
  - Issuing a write to a register whose cnt is decrementing: the new value wins.
  - rd==rs1 on a load (e.g. lw x5,0(x5)): RAW is checked against pre-update state, so no self-stall.

Test Plan:
1. LOAD_LAT=1. Cycle 0: LOAD x5 issues. Cycle 1: ADD x6,x5,x1 -> stall_if=1, ex_bubble=1. Cycle 2: issue_fire=1. stall_cycles=1.
2. ALU writes x5, then ADD uses x5 next cycle -> no stall, sb_busy_mask stays 0.
3. DIV_LAT=8. DIV x7 issues, then ADD uses x7 -> 8 stall cycles, then fire. A second DIV (no register dependence) right behind the first also stalls 8 cycles on div_cnt.
4. DIV x9, then ALU writing x9 -> stalls until cnt[9]==0. Repeat with LOAD writing x9 (LOAD_LAT=1) -> fires when cnt[9]==1.
5. LOAD x0, then use of x0 -> no stall, sb_busy_mask==0. SERIAL behind a pending load -> stalls until mask==0 and div_cnt==0.
6. Flush asserted during a RAW stall -> stall_if=0, issue_fire=0, ex_bubble=1. Reset pulse 3 cycles into a DIV -> next cycle sb_busy_mask=0, stall_cycles=0, a dependent instruction fires immediately.

Source files
------------

// File: rtl/issue_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : issue_hazard_ctrl
// Description : Scoreboard issue gate between OF and EX for an in-order RV32
//               pipeline. Tracks per-register result countdowns and divider
//               occupancy, and serialises CSR/fence-class instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module issue_hazard_ctrl #(
    parameter int LATW     = 4,
    parameter int LOAD_LAT = 1,
    parameter int DIV_LAT  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        of_valid,
    input  logic [4:0]  of_rs1,
    input  logic        of_rs1_used,
    input  logic [4:0]  of_rs2,
    input  logic        of_rs2_used,
    input  logic [4:0]  of_rd,
    input  logic        of_wb_en,
    input  logic [1:0]  of_class,
    input  logic        flush,
    output logic        issue_fire,
    output logic        ex_bubble,
    output logic        stall_if,
    output logic        stall_ifof,
    output logic [31:0] sb_busy_mask,
    output logic [31:0] stall_cycles
);

    localparam logic [1:0]      c_CLS_ALU    = 2'd0;
    localparam logic [1:0]      c_CLS_LOAD   = 2'd1;
    localparam logic [1:0]      c_CLS_DIV    = 2'd2;
    localparam logic [1:0]      c_CLS_SERIAL = 2'd3;
    localparam logic [LATW-1:0] c_LOAD_LAT   = LATW'(LOAD_LAT);
    localparam logic [LATW-1:0] c_DIV_LAT    = LATW'(DIV_LAT);
    localparam logic [LATW-1:0] c_ONE        = LATW'(1);

    // Entry 0 is held at zero so x0 can be indexed without special-casing.
    logic [LATW-1:0] r_cnt [32];
    logic [LATW-1:0] r_div_cnt;
    logic [31:0]     r_stall_cycles;

    logic [LATW-1:0] w_lat;
    logic [31:0]     w_busy;
    logic            w_raw;
    logic            w_waw;
    logic            w_struct;
    logic            w_serial;
    logic            w_hazard;
    logic            w_fire;
    logic            w_stall;
    logic            w_sb_write;

    always_comb begin
        w_lat = '0;
        case (of_class)
            c_CLS_ALU:    w_lat = '0;
            c_CLS_LOAD:   w_lat = c_LOAD_LAT;
            c_CLS_DIV:    w_lat = c_DIV_LAT;
            c_CLS_SERIAL: w_lat = '0;
            default:      w_lat = '0;
        endcase
    end

    always_comb begin
        w_busy = '0;
        for (int r = 1; r < 32; r++) begin
            w_busy[r] = (r_cnt[r] != '0);
        end
    end

    assign w_raw    = (of_rs1_used && (of_rs1 != 5'd0) && w_busy[of_rs1]) ||
                      (of_rs2_used && (of_rs2 != 5'd0) && w_busy[of_rs2]);
    // A younger writer may issue once its own result cannot land before the older one.
    assign w_waw    = of_wb_en && (of_rd != 5'd0) && (r_cnt[of_rd] > w_lat);
    assign w_struct = (of_class == c_CLS_DIV) && (r_div_cnt != '0);
    assign w_serial = (of_class == c_CLS_SERIAL) && ((w_busy != '0) || (r_div_cnt != '0));
    assign w_hazard = w_raw || w_waw || w_struct || w_serial;

    assign w_fire     = of_valid && !flush && !w_hazard;
    assign w_stall    = of_valid && !flush && w_hazard;
    assign w_sb_write = w_fire && of_wb_en && (of_rd != 5'd0) && (w_lat != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                r_cnt[r] <= '0;
            end
            r_div_cnt      <= '0;
            r_stall_cycles <= '0;
        end else begin
            r_cnt[0] <= '0;
            for (int r = 1; r < 32; r++) begin
                if (r_cnt[r] != '0) begin
                    r_cnt[r] <= r_cnt[r] - c_ONE;
                end
            end
            if (w_sb_write) begin
                r_cnt[of_rd] <= w_lat;
            end

            if (w_fire && (of_class == c_CLS_DIV)) begin
                r_div_cnt <= c_DIV_LAT;
            end else if (r_div_cnt != '0) begin
                r_div_cnt <= r_div_cnt - c_ONE;
            end

            if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign issue_fire   = w_fire;
    assign ex_bubble    = !w_fire;
    assign stall_if     = w_stall;
    assign stall_ifof   = w_stall;
    assign sb_busy_mask = w_busy;
    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_issue_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_issue_hazard_ctrl
// Description : Directed bench for issue_hazard_ctrl; timestamp-based model
//               plus hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_hazard_ctrl;

    localparam int LATW     = 4;
    localparam int LOAD_LAT = 1;
    localparam int DIV_LAT  = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        of_valid = 1'b0;
    logic [4:0]  of_rs1 = '0;
    logic        of_rs1_used = 1'b0;
    logic [4:0]  of_rs2 = '0;
    logic        of_rs2_used = 1'b0;
    logic [4:0]  of_rd = '0;
    logic        of_wb_en = 1'b0;
    logic [1:0]  of_class = '0;
    logic        flush = 1'b0;
    logic        issue_fire;
    logic        ex_bubble;
    logic        stall_if;
    logic        stall_ifof;
    logic [31:0] sb_busy_mask;
    logic [31:0] stall_cycles;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    // Model state: absolute cycle at which each result becomes forwardable.
    longint      ready [32];
    longint      div_free = 0;
    longint      now = 0;
    logic [31:0] m_stalls = '0;

    issue_hazard_ctrl #(.LATW(LATW), .LOAD_LAT(LOAD_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .of_valid(of_valid),
        .of_rs1(of_rs1), .of_rs1_used(of_rs1_used),
        .of_rs2(of_rs2), .of_rs2_used(of_rs2_used),
        .of_rd(of_rd), .of_wb_en(of_wb_en), .of_class(of_class), .flush(flush),
        .issue_fire(issue_fire), .ex_bubble(ex_bubble),
        .stall_if(stall_if), .stall_ifof(stall_ifof),
        .sb_busy_mask(sb_busy_mask), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    function automatic longint lat_of(input logic [1:0] cls);
        case (cls)
            2'd1:    return longint'(LOAD_LAT);
            2'd2:    return longint'(DIV_LAT);
            default: return 0;
        endcase
    endfunction

    function automatic longint remaining(input logic [4:0] r);
        if (r == 5'd0 || ready[r] <= now) return 0;
        return ready[r] - now;
    endfunction

    // Compare process: evaluates the model against current inputs each cycle.
    initial begin
        for (int r = 0; r < 32; r++) ready[r] = 0;
        forever begin : cmp
            logic        hz;
            logic        e_fire;
            logic        e_stall;
            logic [31:0] e_mask;
            longint      lat;
            @(negedge clk);
            lat    = lat_of(of_class);
            e_mask = '0;
            for (int r = 1; r < 32; r++) e_mask[r] = (remaining(5'(r)) > 0);
            hz = (of_rs1_used && remaining(of_rs1) > 0) ||
                 (of_rs2_used && remaining(of_rs2) > 0) ||
                 (of_wb_en && remaining(of_rd) > lat) ||
                 (of_class == 2'd2 && div_free > now) ||
                 (of_class == 2'd3 && (e_mask != 0 || div_free > now));
            e_fire  = of_valid && !flush && !hz;
            e_stall = of_valid && !flush && hz;
            if (chk_en) begin
                check("cmp_issue_fire", 32'(issue_fire), 32'(e_fire));
                check("cmp_ex_bubble", 32'(ex_bubble), 32'(!e_fire));
                check("cmp_stall_if", 32'(stall_if), 32'(e_stall));
                check("cmp_stall_ifof", 32'(stall_ifof), 32'(e_stall));
                check("cmp_busy_mask", sb_busy_mask, e_mask);
                check("cmp_stall_cycles", stall_cycles, m_stalls);
            end
            if (reset) begin
                for (int r = 0; r < 32; r++) ready[r] = 0;
                div_free = 0;
                m_stalls = '0;
            end else begin
                if (e_fire && of_wb_en && of_rd != 5'd0 && lat > 0) ready[of_rd] = now + 1 + lat;
                if (e_fire && of_class == 2'd2) div_free = now + 1 + DIV_LAT;
                if (e_stall && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 32'd1;
            end
            now++;
        end
    end

    task automatic drv_full(input logic v, input logic [1:0] cls, input logic [4:0] rd,
                            input logic wb, input logic [4:0] a, input logic ua,
                            input logic [4:0] b, input logic ub, input logic fl,
                            input logic rst);
        @(posedge clk);
        #1;
        of_valid = v; of_class = cls; of_rd = rd; of_wb_en = wb;
        of_rs1 = a; of_rs1_used = ua; of_rs2 = b; of_rs2_used = ub;
        flush = fl; reset = rst;
        #2;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
        drv_full(1'b1, 2'd0, rd, 1'b1, a, 1'b1, b, 1'b1, 1'b0, 1'b0);
    endtask
    task automatic ld(input logic [4:0] rd, input logic [4:0] a);
        drv_full(1'b1, 2'd1, rd, 1'b1, a, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic dv(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
        drv_full(1'b1, 2'd2, rd, 1'b1, a, 1'b1, b, 1'b1, 1'b0, 1'b0);
    endtask
    task automatic ser();
        drv_full(1'b1, 2'd3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic idle();
        drv_full(1'b0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        idle();
        chk_en = 1'b1;
        check("rst_mask", sb_busy_mask, 32'h0);
        check("rst_stall_cycles", stall_cycles, 32'd0);
        check("rst_stall_if", 32'(stall_if), 32'd0);
        check("rst_ex_bubble", 32'(ex_bubble), 32'd1);

        // Load-use: one stall cycle
        ld(5'd5, 5'd1);
        check("t1_load_fire", 32'(issue_fire), 32'd1);
        alu(5'd6, 5'd5, 5'd1);
        check("t1_use_stall", 32'(stall_if), 32'd1);
        check("t1_use_bubble", 32'(ex_bubble), 32'd1);
        check("t1_use_mask", sb_busy_mask, 32'h0000_0020);
        alu(5'd6, 5'd5, 5'd1);
        check("t1_use_fire", 32'(issue_fire), 32'd1);
        idle();
        check("t1_stall_cycles", stall_cycles, 32'd1);

        // ALU-to-ALU: no stall, nothing tracked
        alu(5'd5, 5'd1, 5'd2);
        alu(5'd7, 5'd5, 5'd5);
        check("t2_fire", 32'(issue_fire), 32'd1);
        check("t2_mask", sb_busy_mask, 32'h0);

        // Divide RAW, then back-to-back divides
        dv(5'd7, 5'd1, 5'd2);
        check("t3_div_fire", 32'(issue_fire), 32'd1);
        for (int i = 0; i < 8; i++) begin
            alu(5'd8, 5'd7, 5'd1);
            check("t3_raw_stall", 32'(stall_if), 32'd1);
        end
        alu(5'd8, 5'd7, 5'd1);
        check("t3_raw_fire", 32'(issue_fire), 32'd1);
        check("t3_stall_cycles", stall_cycles, 32'd9);
        dv(5'd10, 5'd1, 5'd2);
        for (int i = 0; i < 8; i++) begin
            dv(5'd11, 5'd3, 5'd4);
            check("t3_struct_stall", 32'(stall_if), 32'd1);
        end
        dv(5'd11, 5'd3, 5'd4);
        check("t3_div2_fire", 32'(issue_fire), 32'd1);
        check("t3_stall_cycles2", stall_cycles, 32'd17);
        repeat (10) idle();

        // WAW behind a divide: ALU waits for zero, LOAD waits for one
        dv(5'd9, 5'd1, 5'd2);
        for (int i = 0; i < 8; i++) begin
            alu(5'd9, 5'd1, 5'd2);
            check("t4_waw_alu_stall", 32'(stall_if), 32'd1);
        end
        alu(5'd9, 5'd1, 5'd2);
        check("t4_waw_alu_fire", 32'(issue_fire), 32'd1);
        check("t4_waw_alu_mask", sb_busy_mask, 32'h0);
        dv(5'd9, 5'd1, 5'd2);
        for (int i = 0; i < 7; i++) begin
            ld(5'd9, 5'd1);
            check("t4_waw_ld_stall", 32'(stall_if), 32'd1);
        end
        ld(5'd9, 5'd1);
        check("t4_waw_ld_fire", 32'(issue_fire), 32'd1);
        check("t4_waw_ld_mask", sb_busy_mask, 32'h0000_0200);
        repeat (3) idle();

        // x0 never tracked; serial instructions drain the pipe
        ld(5'd0, 5'd1);
        alu(5'd6, 5'd0, 5'd0);
        check("t5_x0_fire", 32'(issue_fire), 32'd1);
        check("t5_x0_mask", sb_busy_mask, 32'h0);
        ld(5'd12, 5'd1);
        ser();
        check("t5_ser_ld_stall", 32'(stall_if), 32'd1);
        ser();
        check("t5_ser_ld_fire", 32'(issue_fire), 32'd1);
        dv(5'd13, 5'd1, 5'd2);
        for (int i = 0; i < 8; i++) begin
            ser();
            check("t5_ser_div_stall", 32'(stall_if), 32'd1);
        end
        ser();
        check("t5_ser_div_fire", 32'(issue_fire), 32'd1);
        repeat (10) idle();

        // Flush during a stall, then reset mid-divide
        dv(5'd14, 5'd1, 5'd2);
        alu(5'd15, 5'd14, 5'd1);
        check("t6_pre_flush_stall", 32'(stall_if), 32'd1);
        drv_full(1'b1, 2'd0, 5'd15, 1'b1, 5'd14, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0);
        check("t6_flush_stall_if", 32'(stall_if), 32'd0);
        check("t6_flush_stall_ifof", 32'(stall_ifof), 32'd0);
        check("t6_flush_fire", 32'(issue_fire), 32'd0);
        check("t6_flush_bubble", 32'(ex_bubble), 32'd1);
        drv_full(1'b0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        alu(5'd17, 5'd14, 5'd1);
        check("t6_post_rst_fire", 32'(issue_fire), 32'd1);
        check("t6_post_rst_mask", sb_busy_mask, 32'h0);
        check("t6_post_rst_stalls", stall_cycles, 32'd0);
        idle();

        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
